// File: rtl/ov7670_ctrl_pkg.sv
// ov7670_ctrl_pkg: shared state encoding, classifier colour codes and default frame geometry
// for the OV7670 capture sequencer.
package ov7670_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, SYNC, SKIP, ARM, CAPTURE, LATCH} state_t;
   localparam logic [1:0] CLASS_NONE = 2'b00;
   localparam logic [1:0] CLASS_R    = 2'b01;
   localparam logic [1:0] CLASS_G    = 2'b10;
   localparam logic [1:0] CLASS_B    = 2'b11;
   localparam int DEF_LINES       = 144;
   localparam int DEF_SKIP_FRAMES = 2;
endpackage

// File: rtl/ov7670_edge_det.sv
// ov7670_edge_det: registered-prior rise/fall detector for a Pclock-synchronous camera strobe.
// Ports: Pclock, Reset (sync, active-high), d (strobe); rise/fall are single-cycle
// combinational decodes of d against its value one Pclock earlier.
module ov7670_edge_det (
   input  logic Pclock,
   input  logic Reset,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic prev;
   always_ff @(posedge Pclock) prev <= Reset ? 1'b0 : d;
   assign rise = d & ~prev;
   assign fall = ~d & prev;
endmodule

// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl: frame-capture sequencer for the OV7670 pixel path (Pclock domain).
// Ports: Pclock, Reset (sync, active-high); camera Vsync/Href; control start/continuous/stop;
// classifier class_color/class_shape; result_ack from the consumer. Outputs capture_en gates
// the pixel write path, busy/frame_done report progress, result_* hold the latched
// classification, line_count/frame_err check frame geometry, overrun/timeout are sticky
// faults, frame_cnt counts captured frames.
// Build option: define CAP_TIMEOUT_EN to add the Pclock watchdog driving timeout.
module ov7670_capture_ctrl
   import ov7670_ctrl_pkg::*;
#(
   parameter int LINES          = DEF_LINES,
   parameter int SKIP_FRAMES    = DEF_SKIP_FRAMES,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic             Pclock,
   input  logic             Reset,
   input  logic             Vsync,
   input  logic             Href,
   input  logic             start,
   input  logic             continuous,
   input  logic             stop,
   input  logic [1:0]       class_color,
   input  logic [1:0]       class_shape,
   input  logic             result_ack,
   output logic             capture_en,
   output logic             busy,
   output logic             frame_done,
   output logic             result_valid,
   output logic [1:0]       result_color,
   output logic [1:0]       result_shape,
   output logic [7:0]       line_count,
   output logic             frame_err,
   output logic             overrun,
   output logic             timeout,
   output logic [CNT_W-1:0] frame_cnt
);
   localparam int SK_W = SKIP_FRAMES > 0 ? $clog2(SKIP_FRAMES + 1) : 1;
   state_t          state;
   logic [SK_W-1:0] skip_cnt;
   logic            mode, stop_pending;
   logic            vs_rise, vs_fall, href_fall, href_rise_unused;
   ov7670_edge_det u_vs (.Pclock(Pclock), .Reset(Reset), .d(Vsync), .rise(vs_rise), .fall(vs_fall));
   ov7670_edge_det u_href (.Pclock(Pclock), .Reset(Reset), .d(Href), .rise(href_rise_unused), .fall(href_fall));
   assign busy = state != IDLE;
`ifdef CAP_TIMEOUT_EN
   localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_cnt;
`else
   localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif
   always_ff @(posedge Pclock) begin
      if (Reset) begin
         state        <= IDLE;
         skip_cnt     <= '0;
         mode         <= 1'b0;
         stop_pending <= 1'b0;
         capture_en   <= 1'b0;
         frame_done   <= 1'b0;
         result_valid <= 1'b0;
         result_color <= CLASS_NONE;
         result_shape <= 2'b00;
         line_count   <= 8'd0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
         frame_cnt    <= '0;
`ifdef CAP_TIMEOUT_EN
         wd_cnt       <= '0;
         timeout      <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (result_ack) result_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mode         <= continuous;
               frame_err    <= 1'b0;
               overrun      <= 1'b0;
               stop_pending <= 1'b0;
               state        <= SYNC;
            end
            // A Vsync rise marks a true frame boundary even if start landed mid-frame.
            SYNC: if (stop) state <= IDLE;
               else if (vs_rise) begin
                  skip_cnt <= SK_W'(SKIP_FRAMES);
                  state    <= (SKIP_FRAMES == 0) ? ARM : SKIP;
               end
            SKIP: if (stop) state <= IDLE;
               else if (vs_rise) begin
                  skip_cnt <= skip_cnt - 1'b1;
                  if (skip_cnt == SK_W'(1)) state <= ARM;
               end
            ARM: if (stop) state <= IDLE;
               else if (vs_fall) begin
                  line_count <= 8'd0;
                  capture_en <= 1'b1;
                  state      <= CAPTURE;
               end
            CAPTURE: begin
               if (stop) stop_pending <= 1'b1;
               if (href_fall && line_count != 8'hFF) line_count <= line_count + 8'd1;
               if (vs_rise) begin
                  capture_en <= 1'b0;
                  state      <= LATCH;
               end
            end
            // Classifier output settles on the Vsync rise, so sample it one cycle later.
            LATCH: begin
               result_color <= class_color;
               result_shape <= class_shape;
               result_valid <= 1'b1;
               frame_done   <= 1'b1;
               frame_cnt    <= frame_cnt + 1'b1;
               if (32'(line_count) != LINES) frame_err <= 1'b1;
               if (result_valid && !result_ack) overrun <= 1'b1;
               stop_pending <= 1'b0;
               state        <= (mode && !stop_pending && !stop) ? ARM : IDLE;
            end
            default: state <= IDLE;
         endcase
`ifdef CAP_TIMEOUT_EN
         if (state == IDLE) begin
            wd_cnt <= '0;
            if (start) timeout <= 1'b0;
         end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_cnt       <= '0;
            capture_en   <= 1'b0;
            stop_pending <= 1'b0;
            timeout      <= 1'b1;
            state        <= IDLE;
         end else
            wd_cnt <= (vs_rise || vs_fall) ? '0 : wd_cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// tb_ov7670_capture_ctrl: directed bench for ov7670_capture_ctrl with LINES=4, SKIP_FRAMES=1.
module tb_ov7670_capture_ctrl;
   import ov7670_ctrl_pkg::*;
   logic        Pclock = 0, Reset = 1, Vsync = 0, Href = 0, start = 0, continuous = 0, stop = 0;
   logic [1:0]  class_color = 0, class_shape = 0;
   logic        result_ack = 0;
   logic        capture_en, busy, frame_done, result_valid, frame_err, overrun, timeout;
   logic [1:0]  result_color, result_shape;
   logic [7:0]  line_count;
   logic [15:0] frame_cnt;
   int          checks = 0, errors = 0, cap_cycles = 0, done_cnt = 0, cap0, done0;

   ov7670_capture_ctrl #(.LINES(4), .SKIP_FRAMES(1), .CNT_W(16), .TIMEOUT_CYCLES(64)) dut (
      .Pclock(Pclock), .Reset(Reset), .Vsync(Vsync), .Href(Href), .start(start),
      .continuous(continuous), .stop(stop), .class_color(class_color), .class_shape(class_shape),
      .result_ack(result_ack), .capture_en(capture_en), .busy(busy), .frame_done(frame_done),
      .result_valid(result_valid), .result_color(result_color), .result_shape(result_shape),
      .line_count(line_count), .frame_err(frame_err), .overrun(overrun), .timeout(timeout),
      .frame_cnt(frame_cnt));

   always #5 Pclock = ~Pclock;

   always @(negedge Pclock) begin
      cap_cycles <= cap_cycles + int'(capture_en);
      done_cnt   <= done_cnt + int'(frame_done);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Pclock);
   endtask

   task automatic lines(input int n);
      repeat (n) begin
         Href = 1; cyc(4);
         Href = 0; cyc(2);
      end
   endtask

   // Vertical blank: classifier result appears one cycle after the rise.
   task automatic vs_pulse(input logic [1:0] c, input logic [1:0] s, input logic ack);
      Vsync = 1; cyc(1);
      class_color = c; class_shape = s; result_ack = ack; cyc(1);
      result_ack = 0; cyc(1);
      Vsync = 0; cyc(2);
   endtask

   task automatic pulse_start(input logic cont);
      continuous = cont; start = 1; cyc(1);
      start = 0; continuous = 0;
   endtask

   task automatic pulse(input int which);
      if (which == 0) result_ack = 1; else stop = 1;
      cyc(1);
      result_ack = 0; stop = 0;
   endtask

   function automatic logic [63:0] all_outs();
      return {29'd0, capture_en, busy, frame_done, result_valid, result_color, result_shape,
              line_count, frame_err, overrun, timeout, frame_cnt};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      cyc(3); Reset = 0; cyc(1);
      chk("reset_outs", all_outs(), 0);
      // single capture, start mid-frame
      vs_pulse(CLASS_NONE, 0, 0); lines(1);
      pulse_start(0);
      chk("t1_busy", busy, 1);
      lines(1);
      cap0 = cap_cycles; done0 = done_cnt;
      vs_pulse(CLASS_NONE, 0, 0); lines(4);
      chk("t1_skip_noncap", cap_cycles - cap0, 0);
      vs_pulse(CLASS_NONE, 0, 0); lines(4);
      chk("t1_cap_en", capture_en, 1);
      chk("t1_lines", line_count, 4);
      vs_pulse(CLASS_R, CLASS_G, 0);
      chk("t1_cap_window", cap_cycles - cap0, 26);
      chk("t1_done", done_cnt - done0, 1);
      chk("t1_result", {result_valid, result_color, result_shape}, 5'b1_01_10);
      chk("t1_fcnt", frame_cnt, 1);
      chk("t1_ferr", frame_err, 0);
      chk("t1_idle", {busy, capture_en}, 0);
      // line mismatch
      pulse(0);
      chk("t2_ack", result_valid, 0);
      pulse_start(0); lines(1);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(0, 0, 0); lines(3);
      vs_pulse(CLASS_B, 2'b01, 0);
      chk("t2_lines", line_count, 3);
      chk("t2_ferr", frame_err, 1);
      chk("t2_result", {result_color, result_shape, frame_cnt}, {4'b11_01, 16'd2});
      chk("t2_ovr", overrun, 0);
      // continuous, no ack, stop in third capture
      pulse(0);
      done0 = done_cnt;
      pulse_start(1); lines(1);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(CLASS_R, 2'b01, 0);
      chk("t3_f1", {frame_cnt, overrun, capture_en, busy}, {16'd3, 3'b011});
      lines(4);
      vs_pulse(CLASS_G, 2'b10, 0);
      chk("t3_f2", {frame_cnt, overrun, result_color, result_shape}, {16'd4, 5'b1_10_10});
      lines(2); pulse(1); lines(2);
      chk("t3_stop_pending_cap", capture_en, 1);
      vs_pulse(CLASS_B, 2'b00, 0);
      chk("t3_f3", {frame_cnt, capture_en, busy, result_color, result_shape}, {16'd5, 6'b00_11_00});
      chk("t3_done", done_cnt - done0, 3);
      chk("t3_ferr", frame_err, 0);
      // ack coincident with LATCH
      pulse(0);
      pulse_start(1); lines(1);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(CLASS_R, 2'b11, 0);
      chk("t4_f1_valid", result_valid, 1);
      lines(4);
      vs_pulse(CLASS_G, 2'b01, 1);
      chk("t4_f2", {result_valid, overrun, result_color, result_shape}, 6'b10_10_01);
      lines(1); pulse(1); lines(3);
      vs_pulse(CLASS_B, 2'b10, 1);
      chk("t4_f3", {frame_cnt, overrun, busy}, {16'd8, 2'b00});
      // stop in SKIP
      pulse(0);
      pulse_start(0); lines(1);
      vs_pulse(0, 0, 0); lines(1);
      pulse(1);
      chk("t5_stop_skip", busy, 0);
      cap0 = cap_cycles; done0 = done_cnt;
      vs_pulse(0, 0, 0); lines(4); vs_pulse(0, 0, 0);
      chk("t5_nocap", cap_cycles - cap0, 0);
      chk("t5_nodone", {done_cnt - done0, frame_cnt}, {32'd0, 16'd8});
      // Reset during CAPTURE
      pulse_start(0); lines(1);
      vs_pulse(0, 0, 0); lines(4);
      vs_pulse(0, 0, 0); lines(2);
      chk("t5_in_cap", capture_en, 1);
      Reset = 1; cyc(1);
      chk("t5_reset_outs", all_outs(), 0);
      Reset = 0; done0 = done_cnt;
      vs_pulse(CLASS_R, 0, 0);
      chk("t5_reset_nodone", {done_cnt - done0, 31'd0, busy}, 0);
`ifdef CAP_TIMEOUT_EN
      cyc(2);
      pulse_start(0);
      cyc(63);
      chk("t6_pre_timeout", {busy, timeout}, 2'b10);
      cyc(1);
      chk("t6_timeout", {busy, timeout, capture_en}, 3'b010);
      pulse_start(0);
      chk("t6_restart", {busy, timeout}, 2'b10);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ov7670_capture_ctrl.md
Name: ov7670_capture_ctrl

Overview:
Frame-capture sequencer for the OV7670 pixel path, running in the camera Pclock domain. It:
- waits for a clean frame boundary and skips exposure-settle frames;
- gates the pixel write path (capture_en) for exactly one frame, or continuously;
- checks the line count;
- latches the per-frame colour/shape classification into a valid/ack result register for the CPU-side readout.

Parameters:
LINES, 144, expected Href falling edges per captured frame
SKIP_FRAMES, 2, full frames discarded after SYNC before capture (0 allowed)
CNT_W, 16, width of frame_cnt
TIMEOUT_CYCLES, 1048576, watchdog limit in Pclock cycles (used only with CAP_TIMEOUT_EN)

Ports:
Pclock  in  1  camera pixel clock
Reset  in  1  synchronous active-high reset
Vsync  in  1  camera frame sync, high between frames
Href  in  1  camera line valid
start  in  1  single-cycle capture request
continuous  in  1  mode select, sampled only when start is accepted
stop  in  1  single-cycle request to end capture
class_color  in  2  per-frame colour class from classifier (00 none, 01 R, 10 G, 11 B)
class_shape  in  2  per-frame shape class from classifier
result_ack  in  1  consumer acknowledge of result
capture_en  out  1  enables pixel write path
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse per captured frame
result_valid  out  1  result_color/result_shape hold a fresh result
result_color  out  2  latched class_color
result_shape  out  2  latched class_shape
line_count  out  8  lines counted in the last or current captured frame
frame_err  out  1  sticky: a captured frame had line_count != LINES
overrun  out  1  sticky: a new result arrived while the previous one was unacknowledged
timeout  out  1  sticky watchdog flag; constant 0 without CAP_TIMEOUT_EN
frame_cnt  out  CNT_W  count of captured frames, wraps modulo 2^CNT_W

Behaviour:
- Clock Pclock. Reset is synchronous and active-high (signal Reset).
- On Reset:
  - state IDLE;
  - every output 0;
  - vs_prev, href_prev, stop_pending and mode all 0.
- Reset mid-frame aborts immediately.
- Edge detection uses registered priors: vs_rise = Vsync & ~vs_prev; vs_fall = ~Vsync & vs_prev; href_fall = ~Href & href_prev.
- Outputs are registered; each takes effect the cycle after its triggering condition.
- State machine:
  - IDLE: on start, latch mode = continuous, clear frame_err, overrun and timeout, go to SYNC. stop is ignored in IDLE. start together with stop: start wins and stop is dropped.
  - SYNC: wait for vs_rise, which guarantees a frame boundary even when start arrives mid-frame. Then go to SKIP with skip_cnt = SKIP_FRAMES, or to ARM if SKIP_FRAMES = 0.
  - SKIP: each vs_rise decrements skip_cnt; when it reaches 0, go to ARM.
  - ARM: on vs_fall, go to CAPTURE, clear line_count, set capture_en = 1.
  - CAPTURE: each href_fall increments line_count, saturating at 255. On vs_rise, capture_en = 0 and go to LATCH.
  - LATCH (one cycle):
    - result_color/result_shape <= class_color/class_shape (the classifier updates on the Vsync rise, so the one-cycle delay is mandatory);
    - result_valid = 1, frame_done pulse, frame_cnt++;
    - frame_err |= (line_count != LINES);
    - overrun |= (result_valid & ~result_ack).
    - Next state: ARM if mode = 1 and stop_pending = 0 (no re-skip), else IDLE with stop_pending cleared.
- stop handling:
  - in SYNC, SKIP or ARM: return to IDLE next cycle with no result;
  - in CAPTURE: set stop_pending and finish the current frame.
- start while busy is ignored.
- result_ack clears result_valid next cycle. If ack coincides with LATCH, the new result wins: valid stays 1 and overrun is not set.
- Vsync and Href are already synchronous to Pclock; no synchroniser is required.

Optional Feature:
CAP_TIMEOUT_EN.
- Defined:
  - a watchdog counter runs in every non-IDLE state and clears on entry from IDLE and on any Vsync edge;
  - when it reaches TIMEOUT_CYCLES-1: capture_en = 0, state IDLE, timeout = 1 (sticky until next accepted start), no result produced.
- Undefined: no counter logic; timeout tied to 0.

Decomposition:
- Package ov7670_ctrl_pkg:
  - state enum (IDLE, SYNC, SKIP, ARM, CAPTURE, LATCH);
  - colour class codes (NONE=00, R=01, G=10, B=11);
  - default LINES=144 and SKIP_FRAMES=2.
- One sub-module, ov7670_edge_det: registered rise/fall detector, instantiated for Vsync and Href.

Test Plan:
- Single capture, LINES=4, SKIP_FRAMES=1, start mid-frame, class_color=01/class_shape=10 presented after Vsync rise -> capture_en high only during the 2nd full frame after start; result 01/10; result_valid=1; frame_done one pulse; frame_cnt=1; frame_err=0; back to IDLE.
- Line mismatch: same setup with 3 Href pulses in the captured frame -> line_count=3, frame_err=1.
- Continuous mode, no ack, 3 frames, then stop during the 3rd CAPTURE -> frame_cnt=3; overrun=1 after frame 2; capture_en low after frame 3; IDLE; results track the last classes.
- Ack coincident with LATCH of frame 2 in continuous mode -> result_valid stays 1, overrun=0.
- stop in SKIP, and Reset asserted during CAPTURE -> immediate IDLE; capture_en=0; no frame_done; after Reset all outputs 0.
- With CAP_TIMEOUT_EN and TIMEOUT_CYCLES=64, Vsync held low after start -> IDLE at cycle 64 after entering SYNC; timeout=1; busy=0.
